// File: rtl/mix_pipe.sv
// mix_pipe: elastic DEPTH-stage pipeline carrying data, sum/carry and sel to a muxed output.
// Define MIX_PIPE_SAT_EN to make the add saturate to all-ones on carry.
module mix_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] comb_in,
  input  logic [WIDTH-1:0] comb_add,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] comb_out,
  output logic             c,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] carry_q;
  logic [DEPTH-1:0] sel_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] sum_q  [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   raw_sum;
  logic [WIDTH-1:0] sum_next;
  logic             accept;

  // Advance ripples back from the output, so empty stages collapse while the output is stalled.
  always_comb begin
    logic go;
    go = !v[LAST] || out_ready;
    adv = '0;
    adv[LAST] = go;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      go = !v[k] || go;
      adv[k] = go;
    end
  end

  assign in_ready = adv[0] && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    raw_sum = {1'b0, comb_in} + {1'b0, comb_add};
`ifdef MIX_PIPE_SAT_EN
    sum_next = raw_sum[WIDTH] ? '1 : raw_sum[WIDTH-1:0];
`else
    sum_next = raw_sum[WIDTH-1:0];
`endif
  end

  // Valid bits and counter; clr empties the pipe but leaves payload untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      cnt <= '0;
    end else if (clr) begin
      v   <= '0;
      cnt <= '0;
    end else begin
      if (accept)
        cnt <= cnt + CNT_W'(1);
      for (int k = LAST; k >= 1; k--) begin
        if (adv[k])
          v[k] <= v[k-1];
      end
      if (adv[0])
        v[0] <= in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= '0;
      sel_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        sum_q[k]  <= '0;
      end
    end else begin
      if (adv[0] && in_valid) begin
        data_q[0]  <= data_in;
        sum_q[0]   <= sum_next;
        carry_q[0] <= raw_sum[WIDTH];
        sel_q[0]   <= sel;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k] && v[k-1]) begin
          data_q[k]  <= data_q[k-1];
          sum_q[k]   <= sum_q[k-1];
          carry_q[k] <= carry_q[k-1];
          sel_q[k]   <= sel_q[k-1];
        end
      end
    end
  end

  assign out_valid = v[LAST];
  assign data_out  = data_q[LAST];
  assign comb_out  = sum_q[LAST];
  assign c         = carry_q[LAST];
  assign out       = sel_q[LAST] ? sum_q[LAST] : data_q[LAST];
  assign beat_cnt  = cnt;

endmodule
